// File: rtl/commutator_r2mdc_pkg.sv
// Shared types and constants for the radix-2 MDC delay-commutator.
// The sample width follows the FFT-wide FFTsfpw word width.
`ifndef FFTsfpw
`define FFTsfpw 16
`endif

package commutator_r2mdc_pkg;

  localparam int unsigned NbDefault = `FFTsfpw;

  typedef enum logic {
    SwStraight,
    SwCross
  } sw_mode_e;

  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(2 * depth);
  endfunction

  function automatic int unsigned prime_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/commutator_r2mdc_buffer_en.sv
// Depth-stage register delay line that shifts only when enabled.
// data_o is the sample written Depth enabled cycles earlier.
module commutator_r2mdc_buffer_en #(
    parameter int unsigned Depth = 4,
    parameter int unsigned Width = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic [Width-1:0] data_i,
    output logic [Width-1:0] data_o
);

    logic [Width-1:0] line_q [Depth];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < Depth; i++) begin
                line_q[i] <= '0;
            end
        end else if (en_i) begin
            line_q[0] <= data_i;
            for (int i = 1; i < Depth; i++) begin
                line_q[i] <= line_q[i-1];
            end
        end
    end

    assign data_o = line_q[Depth-1];

endmodule

// File: rtl/commutator_r2mdc.sv
// Radix-2 MDC delay-commutator: delays the lower stream, swaps periodically, then
// delays the upper stream so the next stage sees samples depth apart.
module commutator_r2mdc
    import commutator_r2mdc_pkg::*;
#(
    parameter int unsigned depth = 4,
    localparam int unsigned nb = NbDefault
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    input  logic          in_sop,
    input  logic [nb-1:0] in_a,
    input  logic [nb-1:0] in_b,
    output logic          out_valid,
    output logic [nb-1:0] out_a,
    output logic [nb-1:0] out_b
);

    localparam int unsigned CW = cnt_width(depth);
    localparam int unsigned PW = prime_width(depth);
    localparam logic [CW-1:0] DepthC = CW'(depth);
    localparam logic [CW-1:0] CntLast = CW'(2 * depth - 1);
    localparam logic [PW-1:0] PrimeFull = PW'(depth);

    logic [CW-1:0] cnt_q, cnt_d, cnt_eff;
    logic [PW-1:0] prime_q, prime_d;
    logic          out_valid_q, out_valid_d;
    logic [nb-1:0] out_a_q, out_a_d, out_b_q, out_b_d;
    logic [nb-1:0] bd, top, bot, up_tap;
    sw_mode_e      mode;

    commutator_r2mdc_buffer_en #(
        .Depth (depth),
        .Width (nb)
    ) u_lower_dly (
        .clk    (clk),
        .rst_n  (rst_n),
        .en_i   (in_valid),
        .data_i (in_b),
        .data_o (bd)
    );

    commutator_r2mdc_buffer_en #(
        .Depth (depth),
        .Width (nb)
    ) u_upper_dly (
        .clk    (clk),
        .rst_n  (rst_n),
        .en_i   (in_valid),
        .data_i (top),
        .data_o (up_tap)
    );

    // A start-of-frame sample is switched as phase 0 regardless of the running count.
    assign cnt_eff = in_sop ? '0 : cnt_q;
    assign mode    = (cnt_eff >= DepthC) ? SwCross : SwStraight;

    always_comb begin
        top = in_a;
        bot = bd;
        unique case (mode)
            SwStraight: begin
                top = in_a;
                bot = bd;
            end
            SwCross: begin
                top = bd;
                bot = in_a;
            end
            default: ;
        endcase
    end

    always_comb begin
        cnt_d       = cnt_q;
        prime_d     = prime_q;
        out_a_d     = out_a_q;
        out_b_d     = out_b_q;
        out_valid_d = in_valid && (prime_q == PrimeFull);
        if (in_valid) begin
            cnt_d   = (cnt_eff == CntLast) ? '0 : cnt_eff + 1'b1;
            prime_d = (prime_q == PrimeFull) ? prime_q : prime_q + 1'b1;
            out_a_d = up_tap;
            out_b_d = bot;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            prime_q     <= '0;
            out_valid_q <= 1'b0;
            out_a_q     <= '0;
            out_b_q     <= '0;
        end else begin
            cnt_q       <= cnt_d;
            prime_q     <= prime_d;
            out_valid_q <= out_valid_d;
            out_a_q     <= out_a_d;
            out_b_q     <= out_b_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_a     = out_a_q;
    assign out_b     = out_b_q;

endmodule
